// File: rtl/dmem_responder.sv
// Wait-state data-memory responder for an in-order pipeline's memory stage.
// Accepts one access at a time, inserts WAIT_STATES wait cycles, then returns a one-cycle response.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        stall
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP, ERR} state_t;

    state_t          state;
    state_t          next_state;
    logic [3:0]      wait_cnt;
    logic [AW-1:0]   cap_idx;
    logic [31:0]     cap_wdata;
    logic            cap_write;
    logic [31:0]     rdata_q;
    logic [31:0]     mem [DEPTH_WORDS];

    logic            accept;
    logic            legal;
    logic            commit;
    logic [AW-1:0]   acc_idx;
    logic [31:0]     acc_wdata;
    logic            acc_write;

    assign accept = (state == IDLE) && req_valid;
    assign legal  = (req_addr[1:0] == 2'b00) && ({2'b00, req_addr[31:2]} < 32'(DEPTH_WORDS));

    // With zero wait states the access commits on the acceptance edge, so take request inputs directly in IDLE.
    assign acc_idx   = (state == IDLE) ? req_addr[AW+1:2] : cap_idx;
    assign acc_wdata = (state == IDLE) ? req_wdata : cap_wdata;
    assign acc_write = (state == IDLE) ? req_write : cap_write;
    assign commit    = reset && (next_state == RESP);

    // Next-state decode.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (!legal) begin
                        next_state = ERR;
                    end else if (WAIT_STATES == 0) begin
                        next_state = RESP;
                    end else begin
                        next_state = WAIT;
                    end
                end else begin
                    next_state = IDLE;
                end
            end
            WAIT: begin
                if (wait_cnt == 4'd0) begin
                    next_state = RESP;
                end else begin
                    next_state = WAIT;
                end
            end
            RESP:    next_state = IDLE;
            ERR:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State, wait counter, captured request and response data registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            wait_cnt  <= 4'd0;
            cap_idx   <= '0;
            cap_wdata <= 32'd0;
            cap_write <= 1'b0;
            rdata_q   <= 32'd0;
        end else begin
            state <= next_state;
            if (accept) begin
                cap_idx   <= req_addr[AW+1:2];
                cap_wdata <= req_wdata;
                cap_write <= req_write;
                wait_cnt  <= WAIT_LOAD;
            end else if ((state == WAIT) && (wait_cnt != 4'd0)) begin
                wait_cnt <= wait_cnt - 4'd1;
            end else begin
                wait_cnt <= wait_cnt;
            end
            if (commit) begin
                rdata_q <= acc_write ? acc_wdata : mem[acc_idx];
            end else begin
                rdata_q <= rdata_q;
            end
        end
    end

    // Data array: deliberately not reset so contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (commit && acc_write) begin
            mem[acc_idx] <= acc_wdata;
        end
    end

    assign req_ready  = reset && (state == IDLE);
    assign stall      = reset && (accept || (state == WAIT));
    assign resp_valid = (state == RESP) || (state == ERR);
    assign resp_err   = (state == ERR);
    assign resp_rdata = (state == RESP) ? rdata_q : 32'd0;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: WAIT_STATES=2 main instance plus a WAIT_STATES=0 instance.
module tb_dmem_responder;
    localparam int DEPTH = 256;
    localparam int WS    = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0, req_write = 1'b0;
    logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
    logic        req_ready, resp_valid, resp_err, stall;
    logic [31:0] resp_rdata;

    logic        v0 = 1'b0, w0 = 1'b0;
    logic [31:0] a0 = 32'd0, d0 = 32'd0;
    logic        ready0, rv0, re0, stall0;
    logic [31:0] rd0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        int          cyc;
        logic        err;
        logic [31:0] data;
    } exp_t;
    exp_t        sb_q[$];
    logic [31:0] model [int];

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err), .stall(stall)
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset), .req_valid(v0), .req_write(w0),
        .req_addr(a0), .req_wdata(d0), .req_ready(ready0),
        .resp_valid(rv0), .resp_rdata(rd0), .resp_err(re0), .stall(stall0)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Response monitor: pops the scoreboard on every response strobe.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (resp_valid) begin
                if (sb_q.size() == 0) begin
                    check_val("resp_unexpected", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check_val("resp_cycle", cyc, e.cyc);
                    check_val("resp_err", {31'd0, resp_err}, {31'd0, e.err});
                    check_val("resp_data", resp_rdata, e.data);
                end
            end else begin
                check_val("quiet_err", {31'd0, resp_err}, 32'd0);
                check_val("quiet_data", resp_rdata, 32'd0);
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) check_val("ready_timeout", {31'd0, req_ready}, 32'd1);
    endtask

    task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wd, input bit hold);
        int          lat;
        logic        err;
        exp_t        e;
        wait_ready();
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        #1;
        check_val("stall_accept", {31'd0, stall}, 32'd1);
        err = (addr[1:0] != 2'b00) || (addr[31:2] >= DEPTH);
        lat = err ? 1 : WS + 1;
        e.cyc = cyc + lat;
        e.err = err;
        if (err) e.data = 32'd0;
        else if (wr) e.data = wd;
        else e.data = model.exists(int'(addr[31:2])) ? model[int'(addr[31:2])] : 32'hxxxxxxxx;
        if (!err && wr) model[int'(addr[31:2])] = wd;
        sb_q.push_back(e);
        for (int i = 1; i <= lat; i++) begin
            @(negedge clk);
            if (hold && i < lat) begin
                req_addr  = $urandom;
                req_wdata = $urandom;
                req_write = 1'($urandom_range(0, 1));
            end else begin
                req_valid = 1'b0;
            end
            #1;
            check_val("ready_busy", {31'd0, req_ready}, 32'd0);
            check_val("stall_busy", {31'd0, stall}, (i < lat) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        #1;
        check_val("ready_back", {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        repeat (2) @(negedge clk);
        #1;
        check_val("rst_ready", {31'd0, req_ready}, 32'd0);
        check_val("rst_stall", {31'd0, stall}, 32'd0);
        check_val("rst_valid", {31'd0, resp_valid}, 32'd0);
        reset = 1'b1;
        #1;
        check_val("rel_ready", {31'd0, req_ready}, 32'd1);

        do_req(1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
        do_req(1'b0, 32'h10, 32'h0, 1'b0);
        do_req(1'b1, 32'h13, 32'h11111111, 1'b0);
        do_req(1'b0, 32'h10, 32'h0, 1'b0);
        do_req(1'b0, 32'h400, 32'h0, 1'b0);
        do_req(1'b0, 32'h402, 32'h0, 1'b0);
        do_req(1'b1, 32'h3FC, 32'hCAFEF00D, 1'b0);
        do_req(1'b0, 32'h3FC, 32'h0, 1'b0);

        // Store aborted by a reset pulse in its first wait cycle.
        do_req(1'b1, 32'h20, 32'hA5A5A5A5, 1'b0);
        wait_ready();
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h20;
        req_wdata = 32'h12345678;
        @(negedge clk);
        reset = 1'b0;
        req_valid = 1'b0;
        #1;
        check_val("mid_rst_ready", {31'd0, req_ready}, 32'd0);
        check_val("mid_rst_stall", {31'd0, stall}, 32'd0);
        check_val("mid_rst_valid", {31'd0, resp_valid}, 32'd0);
        check_val("mid_rst_err", {31'd0, resp_err}, 32'd0);
        check_val("mid_rst_data", resp_rdata, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_val("post_rst_ready", {31'd0, req_ready}, 32'd1);
        do_req(1'b0, 32'h20, 32'h0, 1'b0);

        // Inputs churn during WAIT/RESP; the captured request must win.
        do_req(1'b0, 32'h10, 32'h0, 1'b1);
        do_req(1'b1, 32'h44, 32'h0BADC0DE, 1'b1);
        do_req(1'b0, 32'h44, 32'h0, 1'b1);

        for (int i = 0; i < 6; i++) begin
            a = {22'd0, 8'($urandom_range(0, DEPTH - 1)), 2'b00};
            d = $urandom;
            do_req(1'b1, a, d, 1'b0);
            do_req(1'b0, a, 32'h0, 1'b0);
        end

        // Zero-wait-state instance: response one cycle after acceptance.
        @(negedge clk);
        v0 = 1'b1; w0 = 1'b1; a0 = 32'h8; d0 = 32'h00000055;
        #1;
        check_val("ws0_stall", {31'd0, stall0}, 32'd1);
        @(negedge clk);
        v0 = 1'b0;
        #1;
        check_val("ws0_st_valid", {31'd0, rv0}, 32'd1);
        check_val("ws0_st_data", rd0, 32'h00000055);
        check_val("ws0_st_stall", {31'd0, stall0}, 32'd0);
        @(negedge clk);
        v0 = 1'b1; w0 = 1'b0; a0 = 32'h8;
        @(negedge clk);
        v0 = 1'b0;
        #1;
        check_val("ws0_ld_valid", {31'd0, rv0}, 32'd1);
        check_val("ws0_ld_err", {31'd0, re0}, 32'd0);
        check_val("ws0_ld_data", rd0, 32'h00000055);

        repeat (3) @(negedge clk);
        check_val("sb_drain", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
